// File: rtl/string_detect_sched_if.sv
// Request/result bundle between two requesters and the string detection scheduler.
interface string_detect_sched_if #(
  parameter int FRAME_LEN = 20
);
  logic [1:0]           req;
  logic [FRAME_LEN-1:0] frame0;
  logic [FRAME_LEN-1:0] frame1;
  logic [3:0]           pat0;
  logic [3:0]           pat1;
  logic [1:0]           ack;
  logic                 busy;
  logic                 done;
  logic [4:0]           count;
  logic                 done_id;

  modport master (
    output req, frame0, frame1, pat0, pat1,
    input  ack, busy, done, count, done_id
  );

  modport slave (
    input  req, frame0, frame1, pat0, pat1,
    output ack, busy, done, count, done_id
  );
endinterface

// File: rtl/string_detect_sched.sv
// Round-robin scheduled serial 4-bit pattern counter: one job at a time, each job
// shifts a captured frame MSB first through a 4-bit window and counts pattern hits.
module string_detect_sched #(
  parameter int FRAME_LEN = 20,
  parameter int FLUSH_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  string_detect_sched_if.slave bus
);
  localparam int MAX_LEN = (FRAME_LEN > FLUSH_LEN) ? FRAME_LEN : FLUSH_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           win_q, win_d;
  logic [4:0]           mcnt_q, mcnt_d;
  logic                 prio_q, prio_d;
  logic [1:0]           ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [4:0]           count_q, count_d;
  logic                 done_id_q, done_id_d;
  logic [FRAME_LEN-1:0] frame_q, frame_d;
  logic [3:0]           pat_q, pat_d;
  logic                 id_q, id_d;

  logic                 grant;
  logic [3:0]           win_shift;

  // Contended requests go to the priority holder; a lone request always wins.
  function automatic logic pick(input logic [1:0] r, input logic prio);
    if (r == 2'b11) return prio;
    return r[1];
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    mcnt_d    = mcnt_q;
    prio_d    = prio_q;
    ack_d     = 2'b00;
    busy_d    = busy_q;
    done_d    = 1'b0;
    count_d   = count_q;
    done_id_d = done_id_q;
    frame_d   = frame_q;
    pat_d     = pat_q;
    id_d      = id_q;
    grant     = pick(bus.req, prio_q);
    win_shift = {win_q[2:0], frame_q[FRAME_LEN-1]};

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = SHIFT;
          frame_d = grant ? bus.frame1 : bus.frame0;
          pat_d   = grant ? bus.pat1 : bus.pat0;
          id_d    = grant;
          prio_d  = ~grant;
          ack_d   = grant ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
          cnt_d   = '0;
          win_d   = '0;
          mcnt_d  = '0;
        end
      end
      SHIFT: begin
        win_d   = win_shift;
        frame_d = {frame_q[FRAME_LEN-2:0], 1'b0};
        cnt_d   = cnt_q + 1'b1;
        // cnt_q >= 3 means at least four bits are in the window after this shift
        if (cnt_q >= CNT_W'(3) && win_shift == pat_q) mcnt_d = mcnt_q + 1'b1;
        if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(FLUSH_LEN - 1)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          count_d   = mcnt_q;
          done_id_d = id_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      win_q     <= '0;
      mcnt_q    <= '0;
      prio_q    <= 1'b0;
      ack_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      mcnt_q    <= mcnt_d;
      prio_q    <= prio_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      count_q   <= count_d;
      done_id_q <= done_id_d;
    end
  end

  // Captured job data carries no reset; it is reloaded on every acceptance.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
    pat_q   <= pat_d;
    id_q    <= id_d;
  end

  assign bus.ack     = ack_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.count   = count_q;
  assign bus.done_id = done_id_q;
endmodule

// File: tb/tb_string_detect_sched.sv
// Directed bench for string_detect_sched: single jobs, arbitration, reset abort, capture.
module tb_string_detect_sched;
  logic clk;
  logic rst;
  int   passed;
  int   total;

  string_detect_sched_if #(.FRAME_LEN(20)) bus ();

  string_detect_sched #(.FRAME_LEN(20), .FLUSH_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Issue rq, release to rq_after in the ack cycle, then follow the job to its done pulse.
  task automatic do_job(input logic [1:0] rq, input logic [1:0] rq_after,
                        input logic [1:0] exp_ack, input logic [4:0] exp_cnt,
                        input logic exp_id, input bit scramble, input string tag);
    int edges;
    int busy_n;
    bit got;
    bus.req = rq;
    tick();
    check({tag, "_ack"}, 32'(bus.ack), 32'(exp_ack));
    check({tag, "_busy_on"}, 32'(bus.busy), 32'd1);
    bus.req = rq_after;
    if (scramble) begin
      bus.frame0 = 20'h00000;
      bus.pat0   = 4'hA;
    end
    busy_n = 1;
    edges  = 0;
    got    = 1'b0;
    while (!got && edges < 40) begin
      tick();
      edges++;
      if (bus.busy) busy_n++;
      if (edges == 1) check({tag, "_ack_pulse"}, 32'(bus.ack), 32'd0);
      if (bus.done) got = 1'b1;
    end
    check({tag, "_latency"}, 32'(edges), 32'd24);
    check({tag, "_count"}, 32'(bus.count), 32'(exp_cnt));
    check({tag, "_done_id"}, 32'(bus.done_id), 32'(exp_id));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd25);
    tick();
    check({tag, "_done_off"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
    check({tag, "_count_hold"}, 32'(bus.count), 32'(exp_cnt));
  endtask

  initial begin
    bit seen;
    passed     = 0;
    total      = 0;
    rst        = 1'b1;
    bus.req    = 2'b00;
    bus.frame0 = 20'h00000;
    bus.frame1 = 20'h00000;
    bus.pat0   = 4'h0;
    bus.pat1   = 4'h0;
    tick();
    tick();
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_done_id", 32'(bus.done_id), 32'd0);
    rst = 1'b0;

    bus.frame0 = 20'hFFFFF;
    bus.pat0   = 4'hF;
    do_job(2'b01, 2'b00, 2'b01, 5'd17, 1'b0, 1'b0, "sat");

    bus.frame1 = 20'hAAAAA;
    bus.pat1   = 4'b1010;
    do_job(2'b10, 2'b00, 2'b10, 5'd9, 1'b1, 1'b0, "alt");

    bus.frame0 = 20'h00000;
    bus.pat0   = 4'hF;
    do_job(2'b01, 2'b00, 2'b01, 5'd0, 1'b0, 1'b0, "nomatch");

    // Fresh reset so requester 0 holds priority, then both request together.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.frame0 = 20'hFFFFF;
    bus.pat0   = 4'hF;
    do_job(2'b11, 2'b10, 2'b01, 5'd17, 1'b0, 1'b0, "both0");
    do_job(2'b10, 2'b00, 2'b10, 5'd9, 1'b1, 1'b0, "both1");

    bus.req = 2'b01;
    tick();
    check("abort_ack", 32'(bus.ack), 32'd1);
    bus.req = 2'b00;
    repeat (9) tick();
    rst     = 1'b1;
    bus.req = 2'b11;
    tick();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_count", 32'(bus.count), 32'd0);
    check("abort_ack_clr", 32'(bus.ack), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    tick();
    check("rst_over_req_ack", 32'(bus.ack), 32'd0);
    check("rst_over_req_busy", 32'(bus.busy), 32'd0);
    rst     = 1'b0;
    bus.req = 2'b00;
    seen    = 1'b0;
    repeat (30) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    do_job(2'b10, 2'b00, 2'b10, 5'd9, 1'b1, 1'b0, "after_abort");

    bus.frame0 = 20'hFFFFF;
    bus.pat0   = 4'hF;
    do_job(2'b01, 2'b00, 2'b01, 5'd17, 1'b0, 1'b1, "captured");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/string_detect_sched.md
STRING_DETECT_SCHED -- requirements
Module: string_detect_sched

Interface
REQ-001 Parameter FRAME_LEN, default 20, SHALL set the number of serial bits matched per job.
REQ-002 Parameter FLUSH_LEN, default 4, SHALL set the number of post-frame flush cycles.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 req  input  2  SHALL carry the per-requester job request; req[i] is level, held until ack[i].
REQ-006 frame0, frame1  input  FRAME_LEN each  SHALL carry the requester bit frames, serialised MSB first.
REQ-007 pat0, pat1  input  4 each  SHALL carry the requester match patterns; bit 3 is the oldest bit.
REQ-008 ack  output  2  SHALL pulse ack[i] high for one cycle when requester i's job is captured.
REQ-009 busy  output  1  SHALL be high from the acceptance edge until the cycle done is high, inclusive.
REQ-010 done  output  1  SHALL be a one-cycle pulse marking a valid result.
REQ-011 count  output  5  SHALL give the match count of the last completed job.
REQ-012 done_id  output  1  SHALL give the requester index of the last completed job.

Function
REQ-013 States SHALL be IDLE, SHIFT, FLUSH and DONE; there is no other state.
REQ-014 In IDLE with any req bit high, the block SHALL capture the granted frame, pattern and index at that edge and enter SHIFT.
- Bit counter cleared.
- Window cleared.
- Match counter cleared.
REQ-015 ack[g] SHALL be high in the cycle immediately after the acceptance edge, only for granted requester g.
REQ-016 Arbitration SHALL be round-robin: with both req high, grant the requester not granted last; after reset requester 0 has priority.
REQ-017 A single requesting req SHALL be granted regardless of the round-robin pointer.
REQ-018 req SHALL be ignored outside IDLE; the requester drops req in the ack cycle, and a req still high on return to IDLE starts a new job.
REQ-019 In SHIFT, each edge SHALL shift the next frame bit, MSB first, into a 4-bit window (window <= {window[2:0], bit}) and increment the bit counter.
REQ-020 On a SHIFT edge where the bit counter, after the shift, is at least 4 and the new window equals the pattern, the match counter SHALL increment.
- Overlapping matches count.
- Maximum count is FRAME_LEN-3 (17 at default), so the counter never wraps.
REQ-021 After FRAME_LEN SHIFT edges the block SHALL enter FLUSH.
- FLUSH lasts FLUSH_LEN edges.
- No matching and no counter update during FLUSH.
REQ-022 On the last FLUSH edge the block SHALL enter DONE.
REQ-023 In the DONE cycle, done SHALL be high and count/done_id updated; the next edge returns to IDLE.
REQ-024 done SHALL be high exactly FRAME_LEN+FLUSH_LEN (24) edges after the acceptance edge.
REQ-025 count and done_id SHALL hold their values from the DONE cycle until the next DONE cycle.
REQ-026 Back-to-back jobs SHALL be spaced at least one IDLE cycle apart: DONE, then IDLE, then the acceptance edge.

Reset
REQ-027 rst high at an edge SHALL force IDLE and clear the following: ack=0, busy=0, done=0, count=0, done_id=0, window, counters, and round-robin pointer (requester 0 priority).
REQ-028 rst mid-job SHALL abort the job with no done pulse and no further ack for that job.
REQ-029 rst SHALL override any simultaneous req.

Verification
REQ-030 Single job, saturating match: req=01, frame0=20'hFFFFF, pat0=4'hF -> required response:
- ack=01 next cycle
- done 24 edges after acceptance
- count=17, done_id=0
REQ-031 Alternating pattern: frame1=20'hAAAAA, pat1=4'b1010, req=10 -> count=9, done_id=1.
REQ-032 No match: frame0=20'h00000, pat0=4'hF -> count=0 with done pulse; busy high for 25 cycles total.
REQ-033 Simultaneous requests after reset: req=11 held per protocol -> required response:
- requester 0 served first (done_id=0)
- requester 1 accepted on the IDLE cycle after DONE (done_id=1)
- exactly one ack bit high per acceptance
REQ-034 Reset mid-job: assert rst 10 edges after acceptance -> required response:
- busy=0 and count=0 next cycle
- no done pulse
- a new req=10 is then accepted normally
REQ-035 Pattern change mid-job: alter pat0/frame0 after ack -> result SHALL reflect the captured values only.
